// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory stage: RV32I memory opcodes, funct3
// encodings for loads and stores, the transfer FSM state encoding, and
// helpers that decode funct3 into a byte count and a sign-extension flag.
package mem_stage_pkg;

   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      XFER = 3'd2,
      LAST = 3'd3,
      DONE = 3'd4
   } state_t;

   // Index of the final byte of the access (N-1). Any funct3 that is not a
   // legal width for the opcode falls back to a full word.
   function automatic logic [1:0] last_index(input logic [2:0] f3, input logic is_load);
      logic [1:0] idx;
      idx = 2'd3;
      if (is_load) begin
         case (f3)
            LB, LBU: idx = 2'd0;
            LH, LHU: idx = 2'd1;
            default: idx = 2'd3;
         endcase
      end else begin
         case (f3)
            SB:      idx = 2'd0;
            SH:      idx = 2'd1;
            default: idx = 2'd3;
         endcase
      end
      return idx;
   endfunction

   function automatic logic load_signed(input logic [2:0] f3);
      return (f3 == LB) || (f3 == LH);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
// Combinational assembler for load results: takes the little-endian bytes
// captured from the memory port and extends them to 32 bits.
// Ports:
//   captured  in  32  byte i of the access in bits [8i+7:8i]
//   last_idx  in   2  N-1 (0 = byte, 1 = half, 3 = word)
//   sign_ext  in   1  sign-extend byte/half results (LB/LH)
//   value     out 32  assembled load result
module mem_load_align (
   input  logic [31:0] captured,
   input  logic [1:0]  last_idx,
   input  logic        sign_ext,
   output logic [31:0] value
);
   import mem_stage_pkg::*;

   logic signed [7:0]  b0;
   logic signed [15:0] h0;
   logic signed [31:0] b0_ext;
   logic signed [31:0] h0_ext;

   assign b0     = captured[7:0];
   assign h0     = captured[15:0];
   assign b0_ext = b0;
   assign h0_ext = h0;

   always_comb begin
      value = ZeroWord;
      case (last_idx)
         2'd0:    value = sign_ext ? b0_ext : {24'h0, captured[7:0]};
         2'd1:    value = sign_ext ? h0_ext : {16'h0, captured[15:0]};
         default: value = captured;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory stage of the pipeline. Non-memory results pass straight to MEM/WB
// (and the bypass); loads and stores are executed one byte per cycle over
// the shared byte-wide memory port while stall_req holds the front end.
// Build option: define MEM_FWD_EN to enable the forward_mem_* bypass;
// without it the bypass outputs are tied to zero.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low freezes all state)
//   in_*          EX/MEM register contents, sampled only in IDLE
//   mem_req/mem_grant, mem_a, mem_wr, mem_dout, mem_din  memory port
//   stall_req     hold IF/ID/EX and EX/MEM during a transfer
//   forward_mem_* bypass to ID/EX
//   wb_rd_addr, wb_data  registered outputs to MEM/WB
module mem_stage #(
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              in_valid,
   input  logic [6:0]        in_ins_type,
   input  logic [2:0]        in_ins_details,
   input  logic [4:0]        in_rd_addr,
   input  logic [31:0]       in_alu_result,
   input  logic [31:0]       in_store_data,
   output logic              mem_req,
   input  logic              mem_grant,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   output logic [7:0]        mem_dout,
   input  logic [7:0]        mem_din,
   output logic              stall_req,
   output logic              forward_mem_enable,
   output logic [4:0]        forward_mem_addr,
   output logic [31:0]       forward_mem_data,
   output logic [4:0]        wb_rd_addr,
   output logic [31:0]       wb_data
);
   import mem_stage_pkg::*;

   state_t            state, state_nxt;
   logic [1:0]        k, k_nxt;
   logic [ADDR_W-1:0] base;
   logic [31:0]       sdata;
   logic [31:0]       cap;
   logic [31:0]       load_val;
   logic [1:0]        last_idx;
   logic              is_load;
   logic              sign_ext;
   logic [4:0]        rd;
   logic              is_mem_op;
   logic              accept;

   assign is_mem_op = (in_ins_type == LOAD) || (in_ins_type == STORE);
   // Reset masks acceptance so the combinational outputs show reset values
   // even while EX/MEM still presents a memory op.
   assign accept    = (state == IDLE) && in_valid && is_mem_op && !rst_in;

   mem_load_align u_align (
      .captured (cap),
      .last_idx (last_idx),
      .sign_ext (sign_ext),
      .value    (load_val)
   );

   always_comb begin
      state_nxt          = state;
      k_nxt              = k;
      mem_req            = 1'b0;
      mem_wr             = 1'b0;
      mem_a              = '0;
      mem_dout           = 8'h00;
      stall_req          = 1'b0;
      forward_mem_enable = 1'b0;
      forward_mem_addr   = 5'd0;
      forward_mem_data   = ZeroWord;
      case (state)
         IDLE: begin
            stall_req = accept;
            if (accept) state_nxt = REQ;
`ifdef MEM_FWD_EN
            if (!rst_in && in_valid && !is_mem_op && (in_rd_addr != 5'd0)) begin
               forward_mem_enable = 1'b1;
               forward_mem_addr   = in_rd_addr;
               forward_mem_data   = in_alu_result;
            end
`endif
         end
         REQ: begin
            mem_req   = 1'b1;
            stall_req = 1'b1;
            if (mem_grant) begin
               state_nxt = XFER;
               k_nxt     = 2'd0;
            end
         end
         XFER: begin
            mem_req   = 1'b1;
            stall_req = 1'b1;
            mem_a     = base + ADDR_W'(k);
            if (!is_load) begin
               // A frozen cycle must not repeat the write strobe.
               mem_wr   = rdy_in;
               mem_dout = sdata[{k, 3'b000} +: 8];
            end
            if (k == last_idx) state_nxt = is_load ? LAST : DONE;
            else               k_nxt     = k + 2'd1;
         end
         LAST: begin
            mem_req   = 1'b1;
            stall_req = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
`ifdef MEM_FWD_EN
            if (is_load && (rd != 5'd0)) begin
               forward_mem_enable = 1'b1;
               forward_mem_addr   = rd;
               forward_mem_data   = load_val;
            end
`endif
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         k     <= 2'd0;
      end else if (rdy_in) begin
         state <= state_nxt;
         k     <= k_nxt;
      end
   end

   // Accepting a memory op writes a NOP so MEM/WB does not see the previous
   // instruction again while the transfer runs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wb_rd_addr <= 5'd0;
         wb_data    <= ZeroWord;
      end else if (rdy_in) begin
         if (state == IDLE) begin
            if (in_valid && !is_mem_op) begin
               wb_rd_addr <= in_rd_addr;
               wb_data    <= in_alu_result;
            end else begin
               wb_rd_addr <= 5'd0;
               wb_data    <= ZeroWord;
            end
         end else if (state == DONE) begin
            wb_rd_addr <= is_load ? rd : 5'd0;
            wb_data    <= is_load ? load_val : ZeroWord;
         end
      end
   end

   // Transfer operands and captured bytes; only read while a transfer is
   // active, so they carry no reset.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         if (accept) begin
            base     <= ADDR_W'(in_alu_result);
            sdata    <= in_store_data;
            is_load  <= (in_ins_type == LOAD);
            last_idx <= last_index(in_ins_details, in_ins_type == LOAD);
            sign_ext <= (in_ins_type == LOAD) && load_signed(in_ins_details);
            rd       <= in_rd_addr;
         end
         // mem_din lags its address by one cycle: byte k-1 arrives while k
         // is issued, and the final byte arrives in LAST.
         if (is_load && (state == XFER) && (k != 2'd0))
            cap[{k - 2'd1, 3'b000} +: 8] <= mem_din;
         if (is_load && (state == LAST))
            cap[{last_idx, 3'b000} +: 8] <= mem_din;
      end
   end

endmodule
